// File: rtl/reflet_bus_arbiter.sv
// reflet_bus_arbiter: two-master round-robin arbiter for the Reflet system bus.
// Ports:
//   clk, reset (async, active-high), enable (freezes state when low)
//   m0_*/m1_*  : per-master req, addr, data_out, write_en in; grant out
//   data_in    : bus read data, broadcast unregistered on m_data_in
//   addr, data_out, write_en : muxed bus outputs; busy = either grant
// Optional: define REFLET_BUS_ARBITER_PREEMPT_EN to enable hold-time
// preemption after max_hold contended cycles.
module reflet_bus_arbiter #(
  parameter int wordsize = 16,
  parameter int max_hold = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                m0_req,
  input  logic [wordsize-1:0] m0_addr,
  input  logic [wordsize-1:0] m0_data_out,
  input  logic                m0_write_en,
  output logic                m0_grant,
  input  logic                m1_req,
  input  logic [wordsize-1:0] m1_addr,
  input  logic [wordsize-1:0] m1_data_out,
  input  logic                m1_write_en,
  output logic                m1_grant,
  input  logic [wordsize-1:0] data_in,
  output logic [wordsize-1:0] m_data_in,
  output logic [wordsize-1:0] addr,
  output logic [wordsize-1:0] data_out,
  output logic                write_en,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    G0   = 2'd1,
    G1   = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last;
  logic   w_next_last;

`ifdef REFLET_BUS_ARBITER_PREEMPT_EN
  localparam int CW = (max_hold > 1) ? $clog2(max_hold) : 1;
  logic [CW-1:0] r_hold_cnt;
  logic [CW-1:0] w_next_cnt;
  logic          w_expired;

  assign w_expired = (r_hold_cnt == CW'(max_hold - 1));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
    end else if (enable) begin
      r_state <= w_next;
      r_last  <= w_next_last;
    end
  end

`ifdef REFLET_BUS_ARBITER_PREEMPT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_hold_cnt <= '0;
    else if (enable)
      r_hold_cnt <= w_next_cnt;
  end
`endif

  always_comb begin
    w_next      = r_state;
    w_next_last = r_last;
    unique case (r_state)
      IDLE: begin
        // On a tie the master that was not granted last wins.
        if (m0_req && m1_req)
          w_next = r_last ? G0 : G1;
        else if (m0_req)
          w_next = G0;
        else if (m1_req)
          w_next = G1;
      end
      G0: begin
        if (!m0_req)
          w_next = m1_req ? G1 : IDLE;
`ifdef REFLET_BUS_ARBITER_PREEMPT_EN
        else if (m1_req && w_expired)
          w_next = G1;
`endif
      end
      G1: begin
        if (!m1_req)
          w_next = m0_req ? G0 : IDLE;
`ifdef REFLET_BUS_ARBITER_PREEMPT_EN
        else if (m0_req && w_expired)
          w_next = G0;
`endif
      end
      default: w_next = IDLE;
    endcase
    if (w_next == G0)
      w_next_last = 1'b0;
    else if (w_next == G1)
      w_next_last = 1'b1;
  end

`ifdef REFLET_BUS_ARBITER_PREEMPT_EN
  // Count only while staying in a grant state with the other side waiting.
  always_comb begin
    w_next_cnt = '0;
    if (w_next == r_state) begin
      if ((r_state == G0 && m1_req) || (r_state == G1 && m0_req))
        w_next_cnt = r_hold_cnt + 1'b1;
    end
  end
`endif

  assign m0_grant  = (r_state == G0);
  assign m1_grant  = (r_state == G1);
  assign busy      = m0_grant | m1_grant;
  assign m_data_in = data_in;

  always_comb begin
    addr     = '0;
    data_out = '0;
    write_en = 1'b0;
    if (m0_grant) begin
      addr     = m0_addr;
      data_out = m0_data_out;
      write_en = m0_write_en;
    end else if (m1_grant) begin
      addr     = m1_addr;
      data_out = m1_data_out;
      write_en = m1_write_en;
    end
  end

endmodule
